nibble_serial_adder_ctrl: RTL and testbench

Sequencer that performs wide add/subtract by time-sharing one 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first. The carry is held in a register between nibbles. Operands are captured on a start/busy/done handshake, and the result is published atomically on completion. This block is the controller in front of the team's existing 4-bit adder datapath, used by wider arithmetic and lab top levels.

---
 rtl/arith_pkg.sv | 16 +
 rtl/ripple_carry_adder.sv | 24 ++
 rtl/nibble_serial_adder_ctrl.sv | 155 +++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM encoding and nibble slice width.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder slice shared by the nibble-serial controller.
module ripple_carry_adder
  import arith_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             Cin,
  output logic [NIB_W-1:0] S,
  output logic             Cout
);

  // Ripple the carry through one full adder per bit.
  always_comb begin : ripple
    logic c;
    c = Cin;
    S = {NIB_W{1'b0}};
    for (int i = 0; i < NIB_W; i++) begin
      S[i] = A[i] ^ B[i] ^ c;
      c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer: one nibble per clock through a
// single 4-bit slice, LSB first, with the result published atomically.
module nibble_serial_adder_ctrl
  import arith_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sub,
  input  logic                     cin,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     part_q, part_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIB_W-1:0] a_nib_s, b_nib_s, s_nib_s;
  logic             c_out_s;
  logic [W-1:0]     part_next_s;

  // Select the operand nibbles addressed by the index and merge the
  // slice result into the partial word.
  always_comb begin
    a_nib_s     = {NIB_W{1'b0}};
    b_nib_s     = {NIB_W{1'b0}};
    part_next_s = part_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib_s = a_q[i*NIB_W +: NIB_W];
        b_nib_s = b_q[i*NIB_W +: NIB_W];
        part_next_s[i*NIB_W +: NIB_W] = s_nib_s;
      end else begin
        part_next_s[i*NIB_W +: NIB_W] = part_q[i*NIB_W +: NIB_W];
      end
    end
  end

  ripple_carry_adder u_slice (
    .A    (a_nib_s),
    .B    (b_nib_s),
    .Cin  (carry_q),
    .S    (s_nib_s),
    .Cout (c_out_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          // Subtract is A + ~B + 1, so invert B here and force the carry.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = {IDX_W{1'b0}};
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        busy_d  = 1'b1;
        part_d  = part_next_s;
        carry_d = c_out_s;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          sum_d   = part_next_s;
          cout_d  = c_out_s;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (part_next_s[W-1] != a_q[W-1]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      part_q  <= {W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {W{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl with NIBBLES=4.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          done_cyc[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [15:0] hold_sum = 16'h0000;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: pop and compare on every done pulse; check sum holds otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sum", {16'h0, sum}, {16'h0, e.sum});
          chk("cout", {31'h0, cout}, {31'h0, e.cout});
          chk("ovf", {31'h0, ovf}, {31'h0, e.ovf});
          hold_sum = e.sum;
        end
      end else if (rst === 1'b1) begin
        hold_sum = 16'h0000;
      end else begin
        chk("sum_hold", {16'h0, sum}, {16'h0, hold_sum});
      end
    end
  end

  // Issue one operation, push its expectation, and measure latency/busy.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       input logic cv, input logic [15:0] es, input logic ec,
                       input logic eo, input bit chk_lat);
    int c;
    int nb;
    exp_t e;
    @(posedge clk); #1;
    a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
    e.sum = es; e.cout = ec; e.ovf = eo;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv; sub = ~sv; cin = ~cv;
    c = 0; nb = 0;
    while (c < 30) begin
      @(negedge clk);
      c++;
      if (busy === 1'b1) nb++;
      if (done === 1'b1) break;
    end
    if (c >= 30) chk("done_timeout", 32'd1, 32'd0);
    if (chk_lat) begin
      chk("latency", c, 32'd5);
      chk("busy_cycles", nb, 32'd5);
    end
    @(negedge clk);
    chk("busy_after_done", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int c;
    // Reset held two cycles with start asserted.
    rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_sum", {16'h0, sum}, 32'd0);
    chk("rst_cout", {31'h0, cout}, 32'd0);
    chk("rst_ovf", {31'h0, ovf}, 32'd0);
    rst = 1'b0; start = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", {31'h0, busy}, 32'd0);

    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op(16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Continuous start with operands changed mid-RUN.
    done_cyc.delete();
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
    exp_q.push_back({16'h3333, 1'b0, 1'b0});
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    a = 16'h4000; b = 16'h4000;
    exp_q.push_back({16'h8000, 1'b0, 1'b1});
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    c = 0;
    while (done_cyc.size() < 2 && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("hs_done_count", done_cyc.size(), 32'd2);
    if (done_cyc.size() >= 2) chk("hs_spacing", done_cyc[1] - done_cyc[0], 32'd6);
    repeat (8) @(negedge clk);
    chk("hs_no_extra", done_cyc.size(), 32'd2);

    // Reset during the second RUN cycle aborts the operation.
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_sum", {16'h0, sum}, 32'd0);
    repeat (6) @(negedge clk);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
